msi_cache_set: RTL and testbench

N-way set-associative cache set for the L1 coherence datapath. It holds per-way tag, 2-bit MSI state and line data. It provides a combinational tag lookup, and performs fill, partial write and coherence state updates on the clock. It also tracks true-LRU ages and nominates a victim with its writeback payload. It sits between the L1 controller FSM and the snoop/bus interface, one instance per set index.

---
 rtl/msi_cache_set_pkg.sv | 26 ++
 rtl/msi_cache_way.sv | 52 +++++
 rtl/msi_cache_set.sv | 134 +++++++++++++
 tb/tb_msi_cache_set.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/msi_cache_set_pkg.sv
// Shared definitions for the L1 cache set: line geometry, MSI encodings and op codes.
package msi_cache_set_pkg;

    localparam int L1_LINE_SIZE = 64;   // bytes per line
    localparam int L1_TAG_WIDTH = 19;   // tag bits

    typedef enum logic [1:0] {
        MSI_I = 2'b00,
        MSI_S = 2'b01,
        MSI_M = 2'b10
    } msi_state_e;

    typedef enum logic [1:0] {
        OP_NOP       = 2'b00,
        OP_FILL      = 2'b01,
        OP_WRITE     = 2'b10,
        OP_SET_STATE = 2'b11
    } cache_op_e;

    // The unused encoding 2'b11 is folded onto Invalid so no decode can see it as valid.
    function automatic logic [1:0] msi_decode(input logic [1:0] raw);
        if (raw == 2'b11) return MSI_I;
        return raw;
    endfunction

endpackage

// File: rtl/msi_cache_way.sv
// One cache way: state, tag and line registers with fill, word-enabled write and state update.
module msi_cache_way
    import msi_cache_set_pkg::*;
#(
    parameter int LINE_SIZE = L1_LINE_SIZE,
    parameter int TAG_WIDTH = L1_TAG_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_fill,
    input  logic                   i_write,
    input  logic                   i_set_state,
    input  logic [TAG_WIDTH-1:0]   i_tag,
    input  logic [1:0]             i_state,
    input  logic [LINE_SIZE*8-1:0] i_data,
    input  logic [LINE_SIZE/8-1:0] i_wen,
    output logic [1:0]             o_state,
    output logic [TAG_WIDTH-1:0]   o_tag,
    output logic [LINE_SIZE*8-1:0] o_data
);

    localparam int WORDS = LINE_SIZE / 8;

    logic [1:0]             r_state;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic [LINE_SIZE*8-1:0] r_data;

    // Fill replaces the whole way; a write merges enabled words and dirties the line; set_state touches only the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= MSI_I;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (i_fill) begin
            r_state <= i_state;
            r_tag   <= i_tag;
            r_data  <= i_data;
        end else if (i_write) begin
            for (int k = 0; k < WORDS; k++) begin
                if (i_wen[k]) r_data[k*64 +: 64] <= i_data[k*64 +: 64];
            end
            r_state <= MSI_M;
        end else if (i_set_state) begin
            r_state <= i_state;
        end
    end

    assign o_state = msi_decode(r_state);
    assign o_tag   = r_tag;
    assign o_data  = r_data;

endmodule

// File: rtl/msi_cache_set.sv
// N-way MSI cache set: combinational lookup, clocked ops, true-LRU ages and victim nomination.
module msi_cache_set
    import msi_cache_set_pkg::*;
#(
    parameter int NUM_WAYS  = 4,
    parameter int LINE_SIZE = L1_LINE_SIZE,
    parameter int TAG_WIDTH = L1_TAG_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [TAG_WIDTH-1:0]          lookup_tag,
    output logic                          hit,
    output logic [$clog2(NUM_WAYS)-1:0]   hit_way,
    output logic [1:0]                    hit_state,
    output logic [LINE_SIZE*8-1:0]        hit_data,
    input  logic                          op_valid,
    input  logic [1:0]                    op,
    input  logic [$clog2(NUM_WAYS)-1:0]   op_way,
    input  logic [TAG_WIDTH-1:0]          op_tag,
    input  logic [1:0]                    op_state,
    input  logic [LINE_SIZE*8-1:0]        op_data,
    input  logic [LINE_SIZE/8-1:0]        op_wen,
    input  logic                          lru_touch,
    input  logic [$clog2(NUM_WAYS)-1:0]   lru_touch_way,
    output logic [$clog2(NUM_WAYS)-1:0]   victim_way,
    output logic [1:0]                    victim_state,
    output logic [TAG_WIDTH-1:0]          victim_tag,
    output logic [LINE_SIZE*8-1:0]        victim_data,
    output logic                          victim_dirty
);

    localparam int WAY_BITS  = $clog2(NUM_WAYS);
    localparam int LINE_BITS = LINE_SIZE * 8;

    logic [1:0]           w_state [NUM_WAYS];
    logic [TAG_WIDTH-1:0] w_tag   [NUM_WAYS];
    logic [LINE_BITS-1:0] w_data  [NUM_WAYS];
    logic [WAY_BITS-1:0]  r_age   [NUM_WAYS];

    logic                w_is_fill;
    logic                w_is_set;
    logic                w_wr_apply;
    logic                w_touch_en;
    logic [WAY_BITS-1:0] w_touch_way;
    logic [WAY_BITS-1:0] w_touch_age;
    logic                w_hit;
    logic [WAY_BITS-1:0] w_hit_way;
    logic                w_inv_found;
    logic [WAY_BITS-1:0] w_inv_way;
    logic [WAY_BITS-1:0] w_lru_way;
    logic [WAY_BITS-1:0] w_victim_way;

    // A write only takes effect on a valid line with at least one enabled word; otherwise it is a full no-op.
    assign w_is_fill   = op_valid && (op == OP_FILL);
    assign w_is_set    = op_valid && (op == OP_SET_STATE);
    assign w_wr_apply  = op_valid && (op == OP_WRITE) && (w_state[op_way] != MSI_I) && (|op_wen);
    assign w_touch_en  = w_is_fill || w_wr_apply || lru_touch;
    assign w_touch_way = (w_is_fill || w_wr_apply) ? op_way : lru_touch_way;
    assign w_touch_age = r_age[w_touch_way];

    for (genvar g = 0; g < NUM_WAYS; g++) begin : g_way
        logic w_sel;
        assign w_sel = (op_way == WAY_BITS'(g));
        msi_cache_way #(
            .LINE_SIZE (LINE_SIZE),
            .TAG_WIDTH (TAG_WIDTH)
        ) u_way (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_fill      (w_is_fill && w_sel),
            .i_write     (w_wr_apply && w_sel),
            .i_set_state (w_is_set && w_sel),
            .i_tag       (op_tag),
            .i_state     (op_state),
            .i_data      (op_data),
            .i_wen       (op_wen),
            .o_state     (w_state[g]),
            .o_tag       (w_tag[g]),
            .o_data      (w_data[g])
        );
    end

    // True-LRU ages: the touched way becomes 0 and every way younger than it ages by one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WAYS; i++) r_age[i] <= WAY_BITS'(i);
        end else if (w_touch_en) begin
            for (int i = 0; i < NUM_WAYS; i++) begin
                if (WAY_BITS'(i) == w_touch_way)  r_age[i] <= '0;
                else if (r_age[i] < w_touch_age)  r_age[i] <= r_age[i] + WAY_BITS'(1);
            end
        end
    end

    // Hit priority encoder: scan downwards so the lowest matching way wins.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if ((w_state[i] != MSI_I) && (w_tag[i] == lookup_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_BITS'(i);
            end
        end
    end

    // Victim: lowest Invalid way if one exists, else the way holding the oldest age.
    always_comb begin
        w_lru_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (r_age[i] == WAY_BITS'(NUM_WAYS - 1)) w_lru_way = WAY_BITS'(i);
        end
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (w_state[i] == MSI_I) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_BITS'(i);
            end
        end
        w_victim_way = w_inv_found ? w_inv_way : w_lru_way;
    end

    assign hit          = w_hit;
    assign hit_way      = w_hit_way;
    assign hit_state    = w_hit ? w_state[w_hit_way] : 2'(MSI_I);
    assign hit_data     = w_hit ? w_data[w_hit_way] : '0;
    assign victim_way   = w_victim_way;
    assign victim_state = w_state[w_victim_way];
    assign victim_tag   = w_tag[w_victim_way];
    assign victim_data  = w_data[w_victim_way];
    assign victim_dirty = (w_state[w_victim_way] == MSI_M);

endmodule

// File: tb/tb_msi_cache_set.sv
// Self-checking bench for msi_cache_set: recency-list model checked every cycle plus directed literal checks.
module tb_msi_cache_set;

    localparam int NW = 4;
    localparam int WB = 2;
    localparam int TW = 19;
    localparam int WD = 8;
    localparam int LB = 512;

    logic          clk;
    logic          rst_n;
    logic [TW-1:0] lookup_tag;
    logic          hit;
    logic [WB-1:0] hit_way;
    logic [1:0]    hit_state;
    logic [LB-1:0] hit_data;
    logic          op_valid;
    logic [1:0]    op;
    logic [WB-1:0] op_way;
    logic [TW-1:0] op_tag;
    logic [1:0]    op_state;
    logic [LB-1:0] op_data;
    logic [WD-1:0] op_wen;
    logic          lru_touch;
    logic [WB-1:0] lru_touch_way;
    logic [WB-1:0] victim_way;
    logic [1:0]    victim_state;
    logic [TW-1:0] victim_tag;
    logic [LB-1:0] victim_data;
    logic          victim_dirty;

    int n_cmp = 0;
    int n_err = 0;

    // Model: per-way contents plus a recency list (index 0 = most recent, last = least recent).
    logic [1:0]    m_state [NW];
    logic [TW-1:0] m_tag   [NW];
    logic [LB-1:0] m_data  [NW];
    int            m_order [NW];

    logic [LB-1:0] line_a, line_b, line_c, line_d, line0, line1, line3, exp1;

    msi_cache_set #(.NUM_WAYS(NW), .LINE_SIZE(64), .TAG_WIDTH(TW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .lookup_tag    (lookup_tag),
        .hit           (hit),
        .hit_way       (hit_way),
        .hit_state     (hit_state),
        .hit_data      (hit_data),
        .op_valid      (op_valid),
        .op            (op),
        .op_way        (op_way),
        .op_tag        (op_tag),
        .op_state      (op_state),
        .op_data       (op_data),
        .op_wen        (op_wen),
        .lru_touch     (lru_touch),
        .lru_touch_way (lru_touch_way),
        .victim_way    (victim_way),
        .victim_state  (victim_state),
        .victim_tag    (victim_tag),
        .victim_data   (victim_data),
        .victim_dirty  (victim_dirty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] dec(input logic [1:0] s);
        return (s == 2'b11) ? 2'b00 : s;
    endfunction

    function automatic logic [LB-1:0] mkline(input logic [31:0] seed);
        logic [LB-1:0] l;
        for (int k = 0; k < WD; k++) l[k*64 +: 64] = {seed, 28'h0, 4'(k)};
        return l;
    endfunction

    task automatic chk(input string nm, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < NW; i++) begin
            m_state[i] = 2'b00;
            m_tag[i]   = '0;
            m_data[i]  = '0;
            m_order[i] = i;
        end
    endtask

    task automatic m_touch(input int w);
        int pos = 0;
        for (int i = 0; i < NW; i++) if (m_order[i] == w) pos = i;
        for (int i = pos; i > 0; i--) m_order[i] = m_order[i-1];
        m_order[0] = w;
    endtask

    task automatic m_step();
        bit touched = 1'b0;
        int w = int'(op_way);
        if (op_valid) begin
            case (op)
                2'b01: begin
                    m_tag[w] = op_tag; m_data[w] = op_data; m_state[w] = op_state;
                    m_touch(w); touched = 1'b1;
                end
                2'b10: begin
                    if (dec(m_state[w]) != 2'b00 && op_wen != '0) begin
                        for (int k = 0; k < WD; k++)
                            if (op_wen[k]) m_data[w][k*64 +: 64] = op_data[k*64 +: 64];
                        m_state[w] = 2'b10;
                        m_touch(w); touched = 1'b1;
                    end
                end
                2'b11: m_state[w] = op_state;
                default: ;
            endcase
        end
        if (!touched && lru_touch) m_touch(int'(lru_touch_way));
    endtask

    // Model follows the DUT's commit edge and its asynchronous reset.
    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else        m_step();
        end
    end

    task automatic compare_all();
        logic          eh = 1'b0;
        logic [WB-1:0] ew = '0;
        int            ev = -1;
        for (int i = 0; i < NW; i++)
            if (!eh && dec(m_state[i]) != 2'b00 && m_tag[i] == lookup_tag) begin eh = 1'b1; ew = WB'(i); end
        for (int i = 0; i < NW; i++)
            if (ev < 0 && dec(m_state[i]) == 2'b00) ev = i;
        if (ev < 0) ev = m_order[NW-1];
        chk("hit",          LB'(hit),          LB'(eh));
        chk("hit_way",      LB'(hit_way),      LB'(ew));
        chk("hit_state",    LB'(hit_state),    LB'(eh ? dec(m_state[ew]) : 2'b00));
        chk("hit_data",     hit_data,          eh ? m_data[ew] : '0);
        chk("victim_way",   LB'(victim_way),   LB'(ev));
        chk("victim_state", LB'(victim_state), LB'(dec(m_state[ev])));
        chk("victim_tag",   LB'(victim_tag),   LB'(m_tag[ev]));
        chk("victim_data",  victim_data,       m_data[ev]);
        chk("victim_dirty", LB'(victim_dirty), LB'(dec(m_state[ev]) == 2'b10));
    endtask

    // Cycle compare on the falling edge, away from commits.
    initial begin
        forever begin
            @(negedge clk);
            compare_all();
        end
    end

    task automatic idle();
        op_valid = 1'b0; op = 2'b00; op_way = '0; op_tag = '0; op_state = 2'b00;
        op_data = '0; op_wen = '0; lru_touch = 1'b0; lru_touch_way = '0;
    endtask

    task automatic step();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic do_op(input logic [1:0] o, input logic [WB-1:0] w, input logic [TW-1:0] t,
                         input logic [1:0] s, input logic [LB-1:0] d, input logic [WD-1:0] we);
        op_valid = 1'b1; op = o; op_way = w; op_tag = t; op_state = s; op_data = d; op_wen = we;
        step();
    endtask

    task automatic touch(input logic [WB-1:0] w);
        lru_touch = 1'b1; lru_touch_way = w;
        step();
    endtask

    task automatic probe(input logic [TW-1:0] t);
        lookup_tag = t;
        @(negedge clk);
    endtask

    task automatic resume();
        @(posedge clk); #1;
    endtask

    initial begin
        line_a = mkline(32'hAAAA_0002);
        line_b = mkline(32'hBBBB_0000);
        line_c = mkline(32'hCCCC_0001);
        line_d = mkline(32'hDDDD_0001);
        line0  = mkline(32'h1000_0000);
        line1  = mkline(32'h1000_0001);
        line3  = mkline(32'h1000_0003);
        exp1   = line1;
        exp1[0*64 +: 64] = line_d[0*64 +: 64];
        exp1[2*64 +: 64] = line_d[2*64 +: 64];

        rst_n = 1'b0; lookup_tag = '0; idle();
        @(negedge clk);
        chk("rst_hit",          LB'(hit),          '0);
        chk("rst_victim_way",   LB'(victim_way),   '0);
        chk("rst_victim_dirty", LB'(victim_dirty), '0);
        chk("rst_hit_data",     hit_data,          '0);
        resume();
        rst_n = 1'b1;

        // Single fill and lookup
        do_op(2'b01, 2'd2, 19'h1234, 2'b01, line_a, '0);
        probe(19'h1234);
        chk("fill_hit",       LB'(hit),        LB'(1'b1));
        chk("fill_hit_way",   LB'(hit_way),    LB'(2'd2));
        chk("fill_hit_state", LB'(hit_state),  LB'(2'b01));
        chk("fill_hit_data",  hit_data,        line_a);
        chk("fill_victim",    LB'(victim_way), LB'(2'd0));
        resume();

        // Fill remaining ways, then LRU ordering
        do_op(2'b01, 2'd0, 19'h100, 2'b01, line0, '0);
        do_op(2'b01, 2'd1, 19'h101, 2'b01, line1, '0);
        do_op(2'b01, 2'd3, 19'h103, 2'b01, line3, '0);
        touch(2'd0); touch(2'd1); touch(2'd2);
        probe(19'h103);
        chk("lru_victim3",      LB'(victim_way),   LB'(2'd3));
        chk("lru_victim3_tag",  LB'(victim_tag),   LB'(19'h103));
        chk("lru_victim3_data", victim_data,       line3);
        chk("lru_victim3_dirty", LB'(victim_dirty), '0);
        resume();
        touch(2'd3);
        probe(19'h103);
        chk("lru_victim0", LB'(victim_way), LB'(2'd0));
        resume();

        // Partial write to way1
        do_op(2'b10, 2'd1, '0, 2'b00, line_d, 8'b0000_0101);
        probe(19'h101);
        chk("wr_hit_way",   LB'(hit_way),   LB'(2'd1));
        chk("wr_hit_state", LB'(hit_state), LB'(2'b10));
        chk("wr_hit_data",  hit_data,       exp1);
        resume();
        touch(2'd0); touch(2'd3); touch(2'd2);
        probe(19'h101);
        chk("wr_victim1",       LB'(victim_way),   LB'(2'd1));
        chk("wr_victim1_dirty", LB'(victim_dirty), LB'(1'b1));
        chk("wr_victim1_data",  victim_data,       exp1);
        resume();

        // Write with no enabled words changes nothing
        do_op(2'b10, 2'd0, '0, 2'b00, line_d, 8'h00);
        probe(19'h100);
        chk("wen0_data",   hit_data,        line0);
        chk("wen0_state",  LB'(hit_state),  LB'(2'b01));
        chk("wen0_victim", LB'(victim_way), LB'(2'd1));
        resume();

        // Snoop downgrades on way1
        touch(2'd1);
        do_op(2'b11, 2'd1, '0, 2'b01, '0, '0);
        probe(19'h101);
        chk("set_s_state",  LB'(hit_state),    LB'(2'b01));
        chk("set_s_victim", LB'(victim_way),   LB'(2'd0));
        chk("set_s_dirty",  LB'(victim_dirty), '0);
        resume();
        do_op(2'b11, 2'd1, '0, 2'b00, '0, '0);
        probe(19'h101);
        chk("set_i_hit",    LB'(hit),        '0);
        chk("set_i_data",   hit_data,        '0);
        chk("set_i_victim", LB'(victim_way), LB'(2'd1));
        resume();

        // Write to an Invalid way is ignored, including its LRU touch
        touch(2'd0); touch(2'd2); touch(2'd3);
        do_op(2'b10, 2'd1, '0, 2'b00, line_d, 8'hFF);
        probe(19'h101);
        chk("wr_inv_hit",   LB'(hit),          '0);
        chk("wr_inv_state", LB'(victim_state), '0);
        resume();
        do_op(2'b11, 2'd1, '0, 2'b01, '0, '0);
        probe(19'h101);
        chk("restore_hit",    LB'(hit),        LB'(1'b1));
        chk("restore_data",   hit_data,        exp1);
        chk("restore_victim", LB'(victim_way), LB'(2'd1));
        resume();

        // Fill wins over a same-cycle lru_touch
        lru_touch = 1'b1; lru_touch_way = 2'd3;
        do_op(2'b01, 2'd0, 19'h200, 2'b10, line_b, '0);
        probe(19'h200);
        chk("prio_hit_way",   LB'(hit_way),    LB'(2'd0));
        chk("prio_hit_state", LB'(hit_state),  LB'(2'b10));
        chk("prio_victim",    LB'(victim_way), LB'(2'd1));
        resume();
        touch(2'd1); touch(2'd1);
        probe(19'h200);
        chk("mru_victim", LB'(victim_way), LB'(2'd2));
        resume();

        // Illegal encoding behaves as Invalid
        do_op(2'b11, 2'd2, '0, 2'b11, '0, '0);
        probe(19'h1234);
        chk("ill_hit",    LB'(hit),          '0);
        chk("ill_victim", LB'(victim_way),   LB'(2'd2));
        chk("ill_vstate", LB'(victim_state), '0);
        chk("ill_dirty",  LB'(victim_dirty), '0);
        resume();

        // Back-to-back writes to one way, then a duplicate tag
        do_op(2'b10, 2'd0, '0, 2'b00, line_a, 8'h0F);
        do_op(2'b10, 2'd0, '0, 2'b00, line_c, 8'h81);
        do_op(2'b01, 2'd3, 19'h200, 2'b01, line_d, '0);
        probe(19'h200);
        chk("dup_hit_way",   LB'(hit_way),   LB'(2'd0));
        chk("dup_hit_state", LB'(hit_state), LB'(2'b10));
        resume();

        // Asynchronous reset mid-sequence
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_hit",          LB'(hit),          '0);
        chk("arst_hit_way",      LB'(hit_way),      '0);
        chk("arst_hit_state",    LB'(hit_state),    '0);
        chk("arst_hit_data",     hit_data,          '0);
        chk("arst_victim_way",   LB'(victim_way),   '0);
        chk("arst_victim_state", LB'(victim_state), '0);
        chk("arst_victim_tag",   LB'(victim_tag),   '0);
        chk("arst_victim_data",  victim_data,       '0);
        chk("arst_victim_dirty", LB'(victim_dirty), '0);
        resume();
        rst_n = 1'b1;
        do_op(2'b01, 2'd1, 19'h55, 2'b10, line_c, '0);
        probe(19'h55);
        chk("post_hit_way", LB'(hit_way),    LB'(2'd1));
        chk("post_victim",  LB'(victim_way), LB'(2'd0));
        resume();
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
